pattern_scan_ctrl: RTL
======================

Name: pattern_scan_ctrl

Overview:
Sequencing controller for the 6-bit shift-register sequence detector datapath. Accepts parallel words over a valid/ready handshake and serialises them MSB-first into the detector window. Compares the window against a software-programmable pattern, counts matches and raises a sticky threshold interrupt. Sits between the bus-side word source and the status/IRQ logic.

Parameters:
WORD_W, 8, bits per input word (serialised MSB first)
PAT_W, 6, detector window / pattern width
CNT_W, 8, match counter width
DEF_PATTERN, 6'b101011, pattern value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word this cycle
in_data  in  WORD_W  input word
cfg_we  in  1  config write strobe
cfg_pattern  in  PAT_W  pattern to detect
cfg_thresh  in  CNT_W  match count that raises irq; 0 = irq disabled
flush  in  1  discard window history, abort current word
irq_clr  in  1  clear irq and match_count
busy  out  1  high while serialising a word
match  out  1  one-cycle pulse: window equals pattern
register  out  PAT_W  current detector window
match_count  out  CNT_W  saturating match count
irq  out  1  sticky threshold interrupt

Behaviour:
- Reset (async, any time incl. mid-word): state=IDLE, window=0, fill=0, pattern=DEF_PATTERN, thresh=0, match_count=0, irq=0, match=0, busy=0, in_ready=1.
- States: IDLE, SHIFT.
- IDLE: in_ready = !flush. Accept when in_valid && in_ready: latch in_data, bit_idx=WORD_W-1, go SHIFT.
- SHIFT: busy=1, in_ready=0; in_valid ignored. Each cycle: window <= {window[PAT_W-2:0], word[bit_idx]}, fill++ (saturates at PAT_W), bit_idx--. After the bit_idx==0 shift, return to IDLE.
- Timing: accept at edge 0; bit i (MSB=1st) enters window at edge i; last bit at edge WORD_W; next accept no earlier than edge WORD_W+1 (one word per WORD_W+1 cycles).
- match is registered: set at a shift edge iff next window == pattern && fill_next == PAT_W; otherwise 0. Visible in the same cycle as the matching register value. Never asserted in IDLE.
- Window history persists across words; overlapping matches all count.
- match_count: +1 per match; saturates at 2^CNT_W-1.
- irq: set when match_count transitions to value == thresh (thresh != 0); sticky until irq_clr or reset.
- irq_clr: match_count=0, irq=0; a match in the same cycle is dropped (clear wins).
- cfg_we: accepted only in IDLE and without flush; loads pattern and thresh, clears window and fill. Ignored in SHIFT (no side effect).
- flush: any state; next edge window=0, fill=0, state=IDLE, match=0; the aborted word is discarded. match_count, irq and config are retained. flush overrides in_valid and cfg_we.
- Widths: fill is clog2(PAT_W+1) bits; bit_idx is clog2(WORD_W) bits; no overflow wrap anywhere.

Decomposition:
- Shared package: state encoding (IDLE/SHIFT), DEF_PATTERN, default widths.
- One sub-module: pattern_shift_match. Contains the window shift register, fill counter and compare, with inputs shift_en, bit_in, clear, pattern and outputs window and match_next. Controller FSM, counter and irq stay in the top level.

Test Plan:
- Reset, send 8'b00101011 -> single match at 8th shift, register=6'b101011, match_count=1, in_ready back high 9 cycles after accept.
- Send 8'b00000101 then 8'b01100000 -> match at 3rd bit of second word (window spans the word boundary), count=1.
- Same two words with flush pulsed between them -> no match, count=0.
- cfg_thresh=2, three matching words -> irq rises with the 2nd match and stays high at count=3. irq_clr -> irq=0, count=0. irq_clr coincident with a match -> count stays 0.
- CNT_W=2, five matches -> count saturates at 3. cfg_we while busy -> pattern unchanged. in_valid held high during SHIFT -> no extra word accepted.
- Assert reset mid-word (after 4th shift) -> all outputs take reset values immediately. After reset release, a new word is accepted normally.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the pattern scan controller: FSM encoding and
// default geometry/pattern values.
package pattern_scan_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned DEF_PAT_W  = 6;
  localparam int unsigned DEF_CNT_W  = 8;

  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN_C = 6'b101011;

endpackage

// File: rtl/pattern_shift_match.sv
// Detector window: shift register, fill counter and pattern compare.
// match_next is the compare result for the value the window takes at the next edge.
module pattern_shift_match #(
  parameter int unsigned PAT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  output logic [PAT_W-1:0] window,
  output logic             match_next
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    window_d   = window_q;
    fill_d     = fill_q;
    match_next = 1'b0;
    if (clear) begin
      window_d = '0;
      fill_d   = '0;
    end else if (shift_en) begin
      window_d = {window_q[PAT_W-2:0], bit_in};
      if (fill_q != FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
      // Only a completely filled window may report a match.
      match_next = (window_d == pattern) && (fill_d == FILL_W'(PAT_W));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

  assign window = window_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word serialiser, match counter and sticky threshold interrupt around the
// pattern_shift_match detector window.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int unsigned     WORD_W      = DEF_WORD_W,
  parameter int unsigned     PAT_W       = DEF_PAT_W,
  parameter int unsigned     CNT_W       = DEF_CNT_W,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PATTERN_C)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              flush,
  input  logic              irq_clr,
  output logic              busy,
  output logic              match,
  output logic [PAT_W-1:0]  register,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match_q, irq_q, irq_d;

  logic               shift_en, cfg_load, clear, match_next;
  logic [PAT_W-1:0]   window;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    bit_idx_d = bit_idx_q;
    pattern_d = pattern_q;
    thresh_d  = thresh_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    shift_en  = 1'b0;
    cfg_load  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !flush;
        cfg_load = cfg_we && !flush;
        if (cfg_load) begin
          pattern_d = cfg_pattern;
          thresh_d  = cfg_thresh;
        end
        if (in_valid && !flush) begin
          word_d    = in_data;
          bit_idx_d = IDX_W'(WORD_W - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          shift_en = 1'b1;
          if (bit_idx_q == '0) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    clear = flush || cfg_load;
  end

  pattern_shift_match #(
    .PAT_W(PAT_W)
  ) u_shift_match (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .bit_in    (word_q[bit_idx_q]),
    .clear     (clear),
    .pattern   (pattern_q),
    .window    (window),
    .match_next(match_next)
  );

  // irq_clr outranks a simultaneous match so a clear is never undone.
  always_comb begin
    count_d = count_q;
    irq_d   = irq_q;
    if (irq_clr) begin
      count_d = '0;
      irq_d   = 1'b0;
    end else if (match_next && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
      if ((thresh_q != '0) && (count_d == thresh_q)) begin
        irq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      bit_idx_q <= '0;
      pattern_q <= DEF_PATTERN;
      thresh_q  <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      bit_idx_q <= bit_idx_d;
      pattern_q <= pattern_d;
      thresh_q  <= thresh_d;
      count_q   <= count_d;
      match_q   <= match_next;
      irq_q     <= irq_d;
    end
  end

  assign register    = window;
  assign match       = match_q;
  assign match_count = count_q;
  assign irq         = irq_q;

endmodule
